// File: rtl/rst_sequencer.sv
// Purpose: stage reset releases (peripherals, then core) from a synchronized PLL lock, with warm reset and lock-loss counting.
// Latency: periph release SYNC_STAGES+1+LOCK_STABLE_CYCLES edges after lock rises, core CORE_DELAY_CYCLES edges later.
// Backpressure: none; free-running, sw_rst_req_i accepted only in RUN and dropped otherwise.
module rst_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CORE_DELAY_CYCLES  = 8,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int CNT_W              = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clk_locked_i,
    input  logic             sw_rst_req_i,
    output logic             rst_periph_n_o,
    output logic             rst_core_n_o,
    output logic             rst_done_o,
    output logic [CNT_W-1:0] lock_lost_cnt_o
);

    // One shared phase counter, sized for the longest of the three intervals.
    localparam int MAX_AB  = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ? LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
    localparam int MAX_CYC = (MAX_AB > RST_HOLD_CYCLES) ? MAX_AB : RST_HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CORE_LAST   = CW'(CORE_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CNT_W-1:0] LOST_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_STABLE,
        S_REL_PERIPH,
        S_RUN,
        S_HOLD
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_periph_n;
    logic                   r_core_n;
    logic                   r_done;
    logic [CNT_W-1:0]       r_lost_cnt;
    logic                   w_lost_sat;

    assign w_lock_s   = r_sync[SYNC_STAGES-1];
    assign w_lost_sat = &r_lost_cnt;

    // Bring the asynchronous PLL lock into the clk domain.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_locked_i};
        end
    end

    // Sequencer: state, phase counter, registered reset outputs and lock-loss count.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state    <= S_WAIT_LOCK;
            r_cnt      <= '0;
            r_periph_n <= 1'b0;
            r_core_n   <= 1'b0;
            r_done     <= 1'b0;
            r_lost_cnt <= '0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    r_cnt <= '0;
                    if (w_lock_s) begin
                        r_state <= S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        // A glitch before first release restarts qualification, not counted as a loss.
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state    <= S_REL_PERIPH;
                        r_cnt      <= '0;
                        r_periph_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_REL_PERIPH, S_RUN, S_HOLD: begin
                    if (!w_lock_s) begin
                        // Lock loss after first release outranks everything, including a warm-reset request.
                        r_state    <= S_WAIT_LOCK;
                        r_cnt      <= '0;
                        r_periph_n <= 1'b0;
                        r_core_n   <= 1'b0;
                        r_done     <= 1'b0;
                        if (!w_lost_sat) begin
                            r_lost_cnt <= r_lost_cnt + LOST_ONE;
                        end
                    end else if (r_state == S_REL_PERIPH) begin
                        if (r_cnt == CORE_LAST) begin
                            r_state  <= S_RUN;
                            r_cnt    <= '0;
                            r_core_n <= 1'b1;
                            r_done   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end else if (r_state == S_RUN) begin
                        if (sw_rst_req_i) begin
                            r_state    <= S_HOLD;
                            r_cnt      <= '0;
                            r_periph_n <= 1'b0;
                            r_core_n   <= 1'b0;
                            r_done     <= 1'b0;
                        end
                    end else begin
                        // Warm reset: lock is still good, so go straight back to staged release.
                        if (r_cnt == HOLD_LAST) begin
                            r_state    <= S_REL_PERIPH;
                            r_cnt      <= '0;
                            r_periph_n <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state    <= S_WAIT_LOCK;
                    r_cnt      <= '0;
                    r_periph_n <= 1'b0;
                    r_core_n   <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign rst_periph_n_o  = r_periph_n;
    assign rst_core_n_o    = r_core_n;
    assign rst_done_o      = r_done;
    assign lock_lost_cnt_o = r_lost_cnt;

endmodule

// File: tb/tb_rst_sequencer.sv
// Purpose: scoreboard bench for rst_sequencer; every output change must match the next expected event.
// Latency: expected edges are hand-computed for SYNC=2, STABLE=16, CORE=4, HOLD=8.
// Backpressure: none; the monitor samples on the falling edge.
module tb_rst_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 16;
    localparam int CDC  = 4;
    localparam int RHC  = 8;
    localparam int CNTW = 2;

    logic            clk = 1'b0;
    logic            arst;
    logic            lock;
    logic            sw;
    logic            rst_periph_n;
    logic            rst_core_n;
    logic            rst_done;
    logic [CNTW-1:0] lost_cnt;

    rst_sequencer #(
        .SYNC_STAGES       (SYNC),
        .LOCK_STABLE_CYCLES(LSC),
        .CORE_DELAY_CYCLES (CDC),
        .RST_HOLD_CYCLES   (RHC),
        .CNT_W             (CNTW)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .clk_locked_i   (lock),
        .sw_rst_req_i   (sw),
        .rst_periph_n_o (rst_periph_n),
        .rst_core_n_o   (rst_core_n),
        .rst_done_o     (rst_done),
        .lock_lost_cnt_o(lost_cnt)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         e;
        logic       p;
        logic       c;
        logic       d;
        logic [7:0] n;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [10:0] prev  = '0;
    logic [10:0] cur;
    exp_t        ex;

    // Monitor: every change of the output vector is one event, checked against the queue head.
    always @(negedge clk) begin
        cur = {rst_periph_n, rst_core_n, rst_done, 6'b0, lost_cnt};
        if (cur !== prev) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change edge=%0d got p/c/d/cnt=%b/%b/%b/%0d required no change",
                         edge_cnt, rst_periph_n, rst_core_n, rst_done, lost_cnt);
            end else begin
                ex = q.pop_front();
                if (edge_cnt != ex.e || cur !== {ex.p, ex.c, ex.d, ex.n}) begin
                    fails++;
                    $display("FAIL event got edge=%0d p/c/d/cnt=%b/%b/%b/%0d required edge=%0d p/c/d/cnt=%b/%b/%b/%0d",
                             edge_cnt, rst_periph_n, rst_core_n, rst_done, lost_cnt,
                             ex.e, ex.p, ex.c, ex.d, ex.n);
                end
            end
        end
        prev = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (edge_cnt < n) tick();
    endtask

    task automatic expect_at(input int e, input logic p, input logic c, input logic d, input int n);
        exp_t x;
        x.e = e; x.p = p; x.c = c; x.d = d; x.n = 8'(n);
        q.push_back(x);
    endtask

    task automatic pulse_sw();
        sw = 1'b1;
        tick();
        sw = 1'b0;
    endtask

    // Raise lock now and expect the full staged release: periph +19, core/done +23.
    task automatic relock(input int k);
        int r;
        r = edge_cnt;
        lock = 1'b1;
        expect_at(r + 19, 1'b1, 1'b0, 1'b0, k);
        expect_at(r + 23, 1'b1, 1'b1, 1'b1, k);
        goto(r + 30);
    endtask

    // Lose lock from a given phase (0 RUN, 1 HOLD, 2 REL_PERIPH, 3 RUN with a simultaneous sw request), then relock.
    task automatic loss_cycle(input int mode, input int pk, input int k);
        int n;
        n = edge_cnt;
        case (mode)
            0: begin
                expect_at(n + 3, 1'b0, 1'b0, 1'b0, k);
                lock = 1'b0;
                goto(n + 6);
            end
            1: begin
                expect_at(n + 1, 1'b0, 1'b0, 1'b0, pk);
                expect_at(n + 5, 1'b0, 1'b0, 1'b0, k);
                pulse_sw();
                goto(n + 2);
                lock = 1'b0;
                goto(n + 8);
            end
            2: begin
                expect_at(n + 1, 1'b0, 1'b0, 1'b0, pk);
                expect_at(n + 9, 1'b1, 1'b0, 1'b0, pk);
                expect_at(n + 10, 1'b0, 1'b0, 1'b0, k);
                pulse_sw();
                goto(n + 7);
                lock = 1'b0;
                goto(n + 12);
            end
            default: begin
                expect_at(n + 3, 1'b0, 1'b0, 1'b0, k);
                lock = 1'b0;
                goto(n + 2);
                pulse_sw();
                goto(n + 14);
            end
        endcase
        relock(k);
    endtask

    initial begin
        int m;
        int n;
        int s;
        int e;
        arst = 1'b0;
        lock = 1'b0;
        sw   = 1'b0;
        repeat (3) tick();

        // Reset state.
        tests++;
        if ({rst_periph_n, rst_core_n, rst_done, lost_cnt} !== '0) begin
            fails++;
            $display("FAIL reset got p/c/d/cnt=%b/%b/%b/%0d required 0/0/0/0",
                     rst_periph_n, rst_core_n, rst_done, lost_cnt);
        end
        arst = 1'b1;
        tick();
        tick();

        // Cold start.
        relock(0);

        // Warm reset from RUN; a second request in REL_PERIPH is dropped.
        m = edge_cnt;
        expect_at(m + 1, 1'b0, 1'b0, 1'b0, 0);
        expect_at(m + 9, 1'b1, 1'b0, 1'b0, 0);
        expect_at(m + 13, 1'b1, 1'b1, 1'b1, 0);
        pulse_sw();
        goto(m + 10);
        pulse_sw();
        goto(m + 20);

        // Lock loss in RUN, ignored request in WAIT_LOCK, then full relock.
        n = edge_cnt;
        expect_at(n + 3, 1'b0, 1'b0, 1'b0, 1);
        lock = 1'b0;
        goto(n + 6);
        pulse_sw();
        goto(n + 8);
        relock(1);

        // Async arst mid-REL_PERIPH, then restart from WAIT_LOCK.
        m = edge_cnt;
        expect_at(m + 1, 1'b0, 1'b0, 1'b0, 1);
        expect_at(m + 9, 1'b1, 1'b0, 1'b0, 1);
        pulse_sw();
        goto(m + 11);
        expect_at(m + 11, 1'b0, 1'b0, 1'b0, 0);
        #2;
        arst = 1'b0;
        tick();
        arst = 1'b1;
        relock(0);

        // Lock glitch during STABLE restarts qualification, no count.
        n = edge_cnt;
        expect_at(n + 3, 1'b0, 1'b0, 1'b0, 1);
        lock = 1'b0;
        goto(n + 6);
        s = edge_cnt;
        expect_at(s + 32, 1'b1, 1'b0, 1'b0, 1);
        expect_at(s + 36, 1'b1, 1'b1, 1'b1, 1);
        lock = 1'b1;
        goto(s + 10);
        lock = 1'b0;
        goto(s + 13);
        lock = 1'b1;
        goto(s + 45);

        // Clear the counter, then walk it to saturation across different loss phases.
        e = edge_cnt;
        expect_at(e, 1'b0, 1'b0, 1'b0, 0);
        arst = 1'b0;
        tick();
        arst = 1'b1;
        relock(0);
        loss_cycle(3, 0, 1);
        loss_cycle(1, 1, 2);
        loss_cycle(2, 2, 3);
        loss_cycle(0, 3, 3);

        repeat (3) tick();
        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_event got none required edge=%0d p/c/d/cnt=%b/%b/%b/%0d",
                     x.e, x.p, x.c, x.d, x.n);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
